// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR sequencing controller: arbitrates the CSR file's single read/write
// ports between CSR instructions and the trap (mepc/mcause save, mtvec jump) and mret sequences.
module csr_trap_ctrl #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  i_trap_req,
   input  logic [DATA_WIDTH-1:0] i_trap_pc,
   input  logic [DATA_WIDTH-1:0] i_trap_cause,
   input  logic                  i_mret,
   input  logic                  i_sw_we,
   input  logic [ADDR_WIDTH-1:0] i_sw_waddr,
   input  logic [DATA_WIDTH-1:0] i_sw_wdata,
   input  logic [ADDR_WIDTH-1:0] i_sw_raddr,
   output logic                  o_sw_ready,
   output logic [DATA_WIDTH-1:0] o_sw_rdata,
   output logic                  o_trap_ack,
   output logic                  o_mret_ack,
   output logic                  o_busy,
   output logic                  o_redirect_valid,
   output logic [DATA_WIDTH-1:0] o_redirect_pc,
   output logic                  o_csr_we,
   output logic [ADDR_WIDTH-1:0] o_csr_waddr,
   output logic [DATA_WIDTH-1:0] o_csr_wdata,
   output logic [ADDR_WIDTH-1:0] o_csr_raddr,
   input  logic [DATA_WIDTH-1:0] i_csr_rdata
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MEPC   = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MCAUSE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MTVEC  = ADDR_WIDTH'(2);

   typedef enum logic [2:0] {
      IDLE,
      SAVE_EPC,
      SAVE_CAUSE,
      JUMP,
      RET
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] epc_q;
   logic [DATA_WIDTH-1:0] cause_q;
   logic                  idle_ok;
   logic                  take_trap;
   logic                  take_mret;
   logic                  take_sw;

   // Acceptance is also gated by arstn so no ack or pass-through write leaks out during reset.
   assign idle_ok   = (state_q == IDLE) && arstn;
   assign take_trap = idle_ok && i_trap_req;
   assign take_mret = idle_ok && i_mret && !i_trap_req;
   assign take_sw   = idle_ok && i_sw_we && !i_trap_req && !i_mret;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q <= IDLE;
         epc_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         if (take_trap) begin
            epc_q   <= i_trap_pc & ~DATA_WIDTH'(1);
            cause_q <= i_trap_cause;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      o_sw_ready       = 1'b0;
      o_trap_ack       = 1'b0;
      o_mret_ack       = 1'b0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = '0;
      o_csr_we         = 1'b0;
      o_csr_waddr      = '0;
      o_csr_wdata      = '0;
      o_csr_raddr      = '0;
      case (state_q)
         IDLE: begin
            o_csr_raddr = i_sw_raddr;
            if (take_trap) begin
               o_trap_ack = 1'b1;
               state_d    = SAVE_EPC;
            end else if (take_mret) begin
               o_mret_ack = 1'b1;
               state_d    = RET;
            end else if (take_sw) begin
               o_sw_ready  = 1'b1;
               o_csr_we    = 1'b1;
               o_csr_waddr = i_sw_waddr;
               o_csr_wdata = i_sw_wdata;
            end
         end
         SAVE_EPC: begin
            o_csr_we    = 1'b1;
            o_csr_waddr = ADDR_MEPC;
            o_csr_wdata = epc_q;
            state_d     = SAVE_CAUSE;
         end
         SAVE_CAUSE: begin
            o_csr_we    = 1'b1;
            o_csr_waddr = ADDR_MCAUSE;
            o_csr_wdata = cause_q;
            state_d     = JUMP;
         end
         JUMP: begin
            o_csr_raddr      = ADDR_MTVEC;
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_csr_rdata & ~DATA_WIDTH'(3);
            state_d          = IDLE;
         end
         RET: begin
            o_csr_raddr      = ADDR_MEPC;
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_csr_rdata;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_busy     = (state_q != IDLE);
   assign o_sw_rdata = i_csr_rdata;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed, table-driven bench for csr_trap_ctrl with a behavioural 4-entry CSR file attached.
module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        arstn;
   logic        i_trap_req, i_mret, i_sw_we;
   logic [63:0] i_trap_pc, i_trap_cause, i_sw_wdata, i_csr_rdata;
   logic [1:0]  i_sw_waddr, i_sw_raddr;
   logic        o_sw_ready, o_trap_ack, o_mret_ack, o_busy, o_redirect_valid, o_csr_we;
   logic [63:0] o_sw_rdata, o_redirect_pc, o_csr_wdata;
   logic [1:0]  o_csr_waddr, o_csr_raddr;

   always #5 clk = ~clk;

   csr_trap_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
      .clk(clk), .arstn(arstn),
      .i_trap_req(i_trap_req), .i_trap_pc(i_trap_pc), .i_trap_cause(i_trap_cause),
      .i_mret(i_mret), .i_sw_we(i_sw_we), .i_sw_waddr(i_sw_waddr), .i_sw_wdata(i_sw_wdata),
      .i_sw_raddr(i_sw_raddr), .o_sw_ready(o_sw_ready), .o_sw_rdata(o_sw_rdata),
      .o_trap_ack(o_trap_ack), .o_mret_ack(o_mret_ack), .o_busy(o_busy),
      .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
      .o_csr_we(o_csr_we), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
      .o_csr_raddr(o_csr_raddr), .i_csr_rdata(i_csr_rdata)
   );

   // CSR file model: synchronous write, combinational read, cleared by the same reset.
   logic [63:0] csr [4];
   always @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < 4; i++) csr[i] <= '0;
      end else if (o_csr_we) begin
         csr[o_csr_waddr] <= o_csr_wdata;
      end
   end
   assign i_csr_rdata = csr[o_csr_raddr];

   typedef struct {
      logic        trap;  logic [63:0] tpc;  logic [63:0] tcause;  logic mret;
      logic        swe;   logic [1:0]  swa;  logic [63:0] swd;     logic [1:0] sra;
      logic        tack;  logic mack;  logic rdy;  logic busy;
      logic        rv;    logic [63:0] rpc;
      logic        we;    logic [1:0]  wa;   logic [63:0] wd;
      logic [1:0]  ra;    logic [63:0] rdata;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;
   vec_t tbl [33];

   task automatic drive(input vec_t v);
      i_trap_req = v.trap;  i_trap_pc = v.tpc;  i_trap_cause = v.tcause;  i_mret = v.mret;
      i_sw_we = v.swe;  i_sw_waddr = v.swa;  i_sw_wdata = v.swd;  i_sw_raddr = v.sra;
   endtask

   task automatic check(input vec_t e, input string name);
      n_vec++;
      if (o_trap_ack !== e.tack || o_mret_ack !== e.mack || o_sw_ready !== e.rdy ||
          o_busy !== e.busy || o_redirect_valid !== e.rv || o_redirect_pc !== e.rpc ||
          o_csr_we !== e.we || o_csr_waddr !== e.wa || o_csr_wdata !== e.wd ||
          o_csr_raddr !== e.ra || o_sw_rdata !== e.rdata) begin
         n_bad++;
         $display("FAIL %s: got tack=%b mack=%b rdy=%b busy=%b rv=%b rpc=%h we=%b wa=%0d wd=%h ra=%0d rd=%h; want tack=%b mack=%b rdy=%b busy=%b rv=%b rpc=%h we=%b wa=%0d wd=%h ra=%0d rd=%h",
                  name, o_trap_ack, o_mret_ack, o_sw_ready, o_busy, o_redirect_valid, o_redirect_pc,
                  o_csr_we, o_csr_waddr, o_csr_wdata, o_csr_raddr, o_sw_rdata,
                  e.tack, e.mack, e.rdy, e.busy, e.rv, e.rpc, e.we, e.wa, e.wd, e.ra, e.rdata);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      drive(v);
      #1;
      check(v, name);
   endtask

   initial begin
      //         trap tpc      tc mret swe swa swd      sra  tack mack rdy busy rv rpc     we wa wd       ra rdata
      tbl[0]  = '{0, 0,       0, 0,   1,  2,  'h8001,  0,   0,   0,   1,  0,   0, 0,      1, 2, 'h8001,  0, 0};
      tbl[1]  = '{1, 'h1003,  2, 0,   0,  0,  0,       0,   1,   0,   0,  0,   0, 0,      0, 0, 0,       0, 0};
      tbl[2]  = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 0, 'h1002,  0, 0};
      tbl[3]  = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 1, 2,       0, 'h1002};
      tbl[4]  = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   1, 'h8000, 0, 0, 0,       2, 'h8001};
      tbl[5]  = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h1002};
      tbl[6]  = '{0, 0,       0, 1,   0,  0,  0,       0,   0,   1,   0,  0,   0, 0,      0, 0, 0,       0, 'h1002};
      tbl[7]  = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   1, 'h1002, 0, 0, 0,       0, 'h1002};
      tbl[8]  = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h1002};
      tbl[9]  = '{1, 'h2000,  5, 0,   1,  2,  'hAAAA,  0,   1,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h1002};
      tbl[10] = '{0, 0,       0, 0,   1,  2,  'hAAAA,  0,   0,   0,   0,  1,   0, 0,      1, 0, 'h2000,  0, 'h1002};
      tbl[11] = '{0, 0,       0, 0,   1,  2,  'hAAAA,  0,   0,   0,   0,  1,   0, 0,      1, 1, 5,       0, 'h2000};
      tbl[12] = '{0, 0,       0, 0,   1,  2,  'hAAAA,  0,   0,   0,   0,  1,   1, 'h8000, 0, 0, 0,       2, 'h8001};
      tbl[13] = '{0, 0,       0, 0,   1,  2,  'hAAAA,  0,   0,   0,   1,  0,   0, 0,      1, 2, 'hAAAA,  0, 'h2000};
      tbl[14] = '{0, 0,       0, 0,   0,  0,  0,       2,   0,   0,   0,  0,   0, 0,      0, 0, 0,       2, 'hAAAA};
      tbl[15] = '{0, 0,       0, 0,   1,  0,  'h40,    0,   0,   0,   1,  0,   0, 0,      1, 0, 'h40,    0, 'h2000};
      tbl[16] = '{0, 0,       0, 0,   1,  2,  'h100,   0,   0,   0,   1,  0,   0, 0,      1, 2, 'h100,   0, 'h40};
      tbl[17] = '{1, 'h3001,  7, 1,   0,  0,  0,       0,   1,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h40};
      tbl[18] = '{0, 0,       0, 1,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 0, 'h3000,  0, 'h40};
      tbl[19] = '{0, 0,       0, 1,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 1, 7,       0, 'h3000};
      tbl[20] = '{0, 0,       0, 1,   0,  0,  0,       0,   0,   0,   0,  1,   1, 'h100,  0, 0, 0,       2, 'h100};
      tbl[21] = '{0, 0,       0, 1,   0,  0,  0,       0,   0,   1,   0,  0,   0, 0,      0, 0, 0,       0, 'h3000};
      tbl[22] = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   1, 'h3000, 0, 0, 0,       0, 'h3000};
      tbl[23] = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h3000};
      tbl[24] = '{1, 'h500,   1, 0,   0,  0,  0,       0,   1,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h3000};
      tbl[25] = '{1, 'h500,   1, 0,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 0, 'h500,   0, 'h3000};
      tbl[26] = '{1, 'h500,   1, 0,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 1, 1,       0, 'h500};
      tbl[27] = '{1, 'h500,   1, 0,   0,  0,  0,       0,   0,   0,   0,  1,   1, 'h100,  0, 0, 0,       2, 'h100};
      tbl[28] = '{1, 'h604,   4, 0,   0,  0,  0,       0,   1,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h500};
      tbl[29] = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 0, 'h604,   0, 'h500};
      tbl[30] = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   0, 0,      1, 1, 4,       0, 'h604};
      tbl[31] = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  1,   1, 'h100,  0, 0, 0,       2, 'h100};
      tbl[32] = '{0, 0,       0, 0,   0,  0,  0,       0,   0,   0,   0,  0,   0, 0,      0, 0, 0,       0, 'h604};

      // Reset with every request asserted: nothing may be acked or written.
      arstn = 1'b0;
      drive('{1, 'h1003, 2, 1, 1, 2, 'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
      #1;
      check('{1, 'h1003, 2, 1, 1, 2, 'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}, "reset_outputs");
      @(negedge clk);
      drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      arstn = 1'b1;

      for (int i = 0; i < 33; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // Reset during SAVE_EPC aborts the sequence; a fresh trap then runs in full.
      apply('{1, 'h700, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h604}, "abort_ack");
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h700, 0, 'h604}, "abort_save_epc");
      #1 arstn = 1'b0;
      #1 check('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "abort_reset_now");
      @(negedge clk);
      #1 check('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "abort_reset_held");
      arstn = 1'b1;
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "abort_no_redirect");
      apply('{0, 0, 0, 0, 1, 2, 'h204, 0, 0, 0, 1, 0, 0, 0, 1, 2, 'h204, 0, 0}, "fresh_mtvec");
      apply('{1, 'h900, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "fresh_ack");
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h900, 0, 0}, "fresh_epc");
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 'h900}, "fresh_cause");
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h204, 0, 0, 0, 2, 'h204}, "fresh_jump");
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h900}, "fresh_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Sequencing controller for the machine-mode CSR file (mepc at address 0, mcause at 1, mtvec at 2, address 3 reserved). It owns the file's single write port and single read port. It arbitrates between the core's CSR instruction accesses and hardware trap/mret sequences. It turns a trap into ordered mepc/mcause writes plus a mtvec redirect, and an mret into a mepc redirect.

## Interface
Parameters:
- DATA_WIDTH, 64, width of CSR data, PCs and cause.
- ADDR_WIDTH, 2, CSR file address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state changes on its rising edge.
- arstn  input  1  asynchronous active-low reset.
- i_trap_req  input  1  trap request; held high until o_trap_ack.
- i_trap_pc  input  DATA_WIDTH  PC of the trapping instruction.
- i_trap_cause  input  DATA_WIDTH  mcause value.
- i_mret  input  1  mret request; held high until o_mret_ack.
- i_sw_we  input  1  CSR instruction write request.
- i_sw_waddr  input  ADDR_WIDTH  CSR instruction write address.
- i_sw_wdata  input  DATA_WIDTH  CSR instruction write data.
- i_sw_raddr  input  ADDR_WIDTH  CSR instruction read address.
- o_sw_ready  output  1  CSR instruction write accepted this cycle.
- o_sw_rdata  output  DATA_WIDTH  read data for the CSR instruction.
- o_trap_ack  output  1  trap accepted this cycle.
- o_mret_ack  output  1  mret accepted this cycle.
- o_busy  output  1  sequence in progress; core must stall.
- o_redirect_valid  output  1  one-cycle PC redirect strobe.
- o_redirect_pc  output  DATA_WIDTH  redirect target.
- o_csr_we  output  1  to CSR file write_en.
- o_csr_waddr  output  ADDR_WIDTH  to CSR file write address.
- o_csr_wdata  output  DATA_WIDTH  to CSR file write data.
- o_csr_raddr  output  ADDR_WIDTH  to CSR file read address.
- i_csr_rdata  input  DATA_WIDTH  from CSR file read data (combinational).

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, JUMP, RET.
- IDLE priority: trap > mret > sw write. All acceptances happen only in IDLE.
- Trap accept:
  - o_trap_ack=1 combinationally in IDLE.
  - Latch i_trap_pc with bit 0 cleared, and latch i_trap_cause.
  - Next state SAVE_EPC.
- SAVE_EPC: o_csr_we=1, waddr=0, wdata=latched pc. Next state SAVE_CAUSE.
- SAVE_CAUSE: o_csr_we=1, waddr=1, wdata=latched cause. Next state JUMP.
- JUMP:
  - o_csr_raddr=2; o_redirect_valid=1.
  - o_redirect_pc = i_csr_rdata with bits [1:0] forced to 0 (direct mode only).
  - Next state IDLE.
- Mret accept (IDLE, no trap): o_mret_ack=1, next state RET.
- RET: o_csr_raddr=0; o_redirect_valid=1; o_redirect_pc = i_csr_rdata. Next state IDLE.
- SW write in IDLE with no trap and no mret:
  - Pass-through: o_csr_we=1, waddr/wdata from the i_sw_* inputs, o_sw_ready=1, same cycle.
  - Otherwise o_sw_ready=0 and the requester holds.
- o_csr_raddr = i_sw_raddr in IDLE, controller-driven in JUMP/RET, 0 in SAVE_*.
- o_sw_rdata = i_csr_rdata always; valid only in IDLE.
- o_busy = (state != IDLE).
- Requests arriving while busy are ignored, not queued; the requester holds them.
- Default outputs when not driven: 0.

## Timing
- Reset (arstn low, asynchronous):
  - State goes to IDLE and the latches clear to 0.
  - All registered-derived outputs are 0: o_busy, o_redirect_valid, o_redirect_pc, o_csr_we, o_csr_waddr, o_csr_wdata, o_csr_raddr (follows i_sw_raddr), o_trap_ack, o_mret_ack, o_sw_ready.
- Reset mid-sequence aborts it; partially written CSRs are cleared by the CSR file's own reset.
- Trap accepted in cycle T:
  - mepc written at edge ending T+1.
  - mcause written at edge ending T+2.
  - Redirect in T+3; IDLE in T+4.
  - o_busy high T+1..T+3.
- Mret accepted in cycle T: redirect in T+1; IDLE in T+2.
- Trap and sw write in the same IDLE cycle: trap acked, o_sw_ready=0, no sw write.
- Trap and mret in the same cycle: trap wins; mret is retried after the trap sequence.
- Back-to-back: a trap held across the JUMP cycle is accepted in the following IDLE cycle (T+4).
- The mtvec read in JUMP sees any sw write to mtvec completed before T.

## Test plan
- Reset, then trap with pc=0x1003, cause=0x2, mtvec preloaded to 0x8001 via sw write:
  - Expect mepc=0x1002 written at T+1 and mcause=0x2 at T+2.
  - Expect redirect_valid and redirect_pc=0x8000 at T+3; busy high T+1..T+3.
- After the above, assert mret → redirect_pc=0x1002 at T+1; busy for 1 cycle.
- Trap and sw write (addr 2, 0xAAAA) in the same cycle:
  - Expect trap_ack=1, sw_ready=0.
  - Sw write completes in the cycle after busy drops; mtvec=0xAAAA.
- Sw write asserted during SAVE_CAUSE → sw_ready=0 and no extra o_csr_we pulse until IDLE.
- arstn low during SAVE_EPC:
  - Expect immediate IDLE with busy=0 and we=0.
  - No redirect is ever issued; a fresh trap after release runs the full 4-cycle sequence.
- Trap and mret together with mepc=0x40, mtvec=0x100:
  - Trap redirect to 0x100 first.
  - Mret accepted at T+4 and redirects to the new mepc.
